ga_population_buffer: RTL and testbench
=======================================

# ga_population_buffer

Double-buffered population store for the GA core. Parent selection reads the current generation through two independent read ports. Crossover/mutation writes the next generation into a shadow bank, and each entry carries a chromosome plus its fitness. A swap handshake commits the shadow bank as the new current generation and publishes the best individual of that generation, replacing the single-bank, read-combinational population memory.

## Interface
- CHROMOSOME_WIDTH, 16, bits per chromosome
- FITNESS_WIDTH, 14, bits per unsigned fitness value
- POPULATION_SIZE, 16, entries per bank; need not be a power of two
- ADDR_WIDTH, $clog2(POPULATION_SIZE), address width
- GEN_WIDTH, 16, generation counter width

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request into shadow bank
- wr_addr  in  ADDR_WIDTH  write address
- wr_chrom  in  CHROMOSOME_WIDTH  chromosome to store
- wr_fit  in  FITNESS_WIDTH  fitness to store
- wr_err  out  1  registered pulse: last write rejected
- wr_count  out  ADDR_WIDTH+1  distinct shadow entries written this generation
- next_full  out  1  wr_count == POPULATION_SIZE
- rd_en_a / rd_en_b  in  1  read request, port A / B
- rd_addr_a / rd_addr_b  in  ADDR_WIDTH  read address into active bank
- rd_chrom_a / rd_chrom_b  out  CHROMOSOME_WIDTH  read chromosome
- rd_fit_a / rd_fit_b  out  FITNESS_WIDTH  read fitness
- rd_valid_a / rd_valid_b  out  1  read data valid
- swap_req  in  1  level request to commit shadow bank
- swap_ack  out  1  swap taken at this edge (combinational)
- best_chrom  out  CHROMOSOME_WIDTH  best chromosome of active generation
- best_fit  out  FITNESS_WIDTH  best fitness of active generation
- best_addr  out  ADDR_WIDTH  address of best entry in active bank
- best_valid  out  1  best_* meaningful (at least one swap since reset)
- generation  out  GEN_WIDTH  completed swaps, wraps modulo 2^GEN_WIDTH

## Operation
- Two banks, bank_sel. Reads use bank bank_sel; writes use bank ~bank_sel.
- Per-address written mask for the shadow bank.
- Write is accepted when all of these hold: wr_en=1, wr_addr<POPULATION_SIZE, mask[wr_addr]=0. An accepted write:
  - stores the entry,
  - sets the mask bit,
  - increments wr_count,
  - updates the shadow-best.
- Write is rejected (wr_err=1 next cycle, no state change) when: address is out of range, address was already written this generation, or a swap is taken this cycle.
- Shadow-best: replaced when wr_fit > stored shadow-best fitness (strict). Ties keep the earlier write. The first accepted write of a generation always loads it.
- swap_ack = swap_req & next_full. swap_req without next_full is held off with no error; the requester keeps it high.
- On a swap edge:
  - bank_sel toggles,
  - mask and wr_count clear,
  - best_* load from shadow-best,
  - best_valid sets,
  - generation increments.
- Reads: rd_en_x sampled at an edge gives rd_chrom_x/rd_fit_x/rd_valid_x from the bank active *before* that edge. A read coincident with a swap returns old-generation data.
- Out-of-range read address returns zero data with rd_valid asserted.
- rd_valid_x drops the cycle after rd_en_x=0. Read data holds its last value.
- Ports A and B are fully independent and may use the same address.
- Before the first swap, active-bank contents are undefined; read data is unchecked, but rd_valid is still correct.

## Timing
- Reset values, all outputs 0: wr_err, wr_count, next_full, rd_*, best_*, generation, bank_sel. The mask also clears; RAM contents are not reset.
- Reset takes priority over any write, read or swap in the same cycle.
- Reset asserted mid-generation discards partial writes (mask cleared).
- Read latency is 1 cycle; one read per port per cycle is sustained.
- Write-to-wr_count/next_full latency is 1 cycle.
- Write to last entry at edge N: next_full=1 after N. swap_ack can assert in cycle N+1. New generation is readable from reads issued at N+2.
- swap_ack has 0-cycle latency from swap_req once next_full=1.
- generation wraps from 2^GEN_WIDTH-1 to 0.

## Structure
- Package ga_pkg holds the default width constants (CHROMOSOME_WIDTH, FITNESS_WIDTH, POPULATION_SIZE) shared with selection and crossover blocks.
- Sub-module population_bank: one synchronous write port and two registered read ports, instantiated twice.
- Mask, counters, best tracking and swap logic stay in the top.

## Test plan
- Reset, then write addresses 0..15 with fitness = 3*addr, then swap:
  - next_full=1 after the 16th write,
  - swap_ack=1 in the swap cycle,
  - afterwards best_fit=45, best_addr=15, best_valid=1, generation=1.
- Rewrite address 4 after it was written; also write address 16 with POPULATION_SIZE=17 disabled (SIZE=12, addr 13):
  - wr_err pulses,
  - wr_count is unchanged,
  - best_* are unaffected.
- Hold swap_req high from reset while writing 15 of 16 entries:
  - no swap_ack,
  - 16th write makes swap_ack=1 the next cycle.
- Tie: entries 2 and 9 both written with fitness 0x3FFF, entry 2 first:
  - best_addr=2 after swap.
- Gen 1 holds data d1 at address 7; write gen 2 with d2; issue rd_addr_a=7 and rd_addr_b=7 in the swap cycle:
  - both ports return d1,
  - a read issued the next cycle returns d2.
- Assert rst after 8 writes of gen 2:
  - all outputs 0 next cycle,
  - 16 fresh writes are required before swap_ack.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared default widths for the GA core (population buffer, selection, crossover).
package ga_pkg;

  localparam int unsigned CHROMOSOME_WIDTH = 16;
  localparam int unsigned FITNESS_WIDTH    = 14;
  localparam int unsigned POPULATION_SIZE  = 16;
  localparam int unsigned GEN_WIDTH        = 16;

endpackage

// File: rtl/population_bank.sv
// One population bank: synchronous write port plus two independent registered
// read ports. Out-of-range read addresses return zero; read data holds when idle.
module population_bank #(
  parameter int unsigned DataWidth = 30,
  parameter int unsigned Depth     = 16,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [AddrWidth-1:0] i_wr_addr,
  input  logic [DataWidth-1:0] i_wr_data,
  input  logic                 i_rd_en_a,
  input  logic [AddrWidth-1:0] i_rd_addr_a,
  output logic [DataWidth-1:0] o_rd_data_a,
  input  logic                 i_rd_en_b,
  input  logic [AddrWidth-1:0] i_rd_addr_b,
  output logic [DataWidth-1:0] o_rd_data_b
);

  localparam logic [AddrWidth:0] DepthW = (AddrWidth + 1)'(Depth);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [DataWidth-1:0] r_rd_data_a;
  logic [DataWidth-1:0] r_rd_data_b;
  logic                 w_rd_ok_a;
  logic                 w_rd_ok_b;

  assign w_rd_ok_a = ({1'b0, i_rd_addr_a} < DepthW);
  assign w_rd_ok_b = ({1'b0, i_rd_addr_b} < DepthW);

  // Storage; the caller only asserts i_wr_en for in-range addresses.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port A register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data_a <= '0;
    end else if (i_rd_en_a) begin
      r_rd_data_a <= w_rd_ok_a ? r_mem[i_rd_addr_a] : '0;
    end
  end

  // Read port B register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data_b <= '0;
    end else if (i_rd_en_b) begin
      r_rd_data_b <= w_rd_ok_b ? r_mem[i_rd_addr_b] : '0;
    end
  end

  assign o_rd_data_a = r_rd_data_a;
  assign o_rd_data_b = r_rd_data_b;

endmodule

// File: rtl/ga_population_buffer.sv
// Double-buffered GA population store. Reads see the active bank, writes fill the
// shadow bank once per address, and a swap commits the shadow bank together with
// the best individual tracked while it was being written.
module ga_population_buffer #(
  parameter int unsigned CHROMOSOME_WIDTH = ga_pkg::CHROMOSOME_WIDTH,
  parameter int unsigned FITNESS_WIDTH    = ga_pkg::FITNESS_WIDTH,
  parameter int unsigned POPULATION_SIZE  = ga_pkg::POPULATION_SIZE,
  parameter int unsigned ADDR_WIDTH       = $clog2(POPULATION_SIZE),
  parameter int unsigned GEN_WIDTH        = ga_pkg::GEN_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [CHROMOSOME_WIDTH-1:0] wr_chrom,
  input  logic [FITNESS_WIDTH-1:0]    wr_fit,
  output logic                        wr_err,
  output logic [ADDR_WIDTH:0]         wr_count,
  output logic                        next_full,
  input  logic                        rd_en_a,
  input  logic [ADDR_WIDTH-1:0]       rd_addr_a,
  output logic [CHROMOSOME_WIDTH-1:0] rd_chrom_a,
  output logic [FITNESS_WIDTH-1:0]    rd_fit_a,
  output logic                        rd_valid_a,
  input  logic                        rd_en_b,
  input  logic [ADDR_WIDTH-1:0]       rd_addr_b,
  output logic [CHROMOSOME_WIDTH-1:0] rd_chrom_b,
  output logic [FITNESS_WIDTH-1:0]    rd_fit_b,
  output logic                        rd_valid_b,
  input  logic                        swap_req,
  output logic                        swap_ack,
  output logic [CHROMOSOME_WIDTH-1:0] best_chrom,
  output logic [FITNESS_WIDTH-1:0]    best_fit,
  output logic [ADDR_WIDTH-1:0]       best_addr,
  output logic                        best_valid,
  output logic [GEN_WIDTH-1:0]        generation
);

  localparam int unsigned       EntryWidth = CHROMOSOME_WIDTH + FITNESS_WIDTH;
  localparam logic [ADDR_WIDTH:0] PopSize  = (ADDR_WIDTH + 1)'(POPULATION_SIZE);
  localparam logic [ADDR_WIDTH:0] CountOne = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [GEN_WIDTH-1:0] GenOne  = {{(GEN_WIDTH - 1){1'b0}}, 1'b1};

  // Bank state and per-generation bookkeeping.
  logic                        r_bank_sel;
  logic [POPULATION_SIZE-1:0]  r_mask;
  logic [ADDR_WIDTH:0]         r_wr_count;
  logic                        r_wr_err;
  logic [GEN_WIDTH-1:0]        r_generation;

  // Best individual of the shadow generation, built up as writes arrive.
  logic [CHROMOSOME_WIDTH-1:0] r_sb_chrom;
  logic [FITNESS_WIDTH-1:0]    r_sb_fit;
  logic [ADDR_WIDTH-1:0]       r_sb_addr;

  // Published best of the active generation.
  logic [CHROMOSOME_WIDTH-1:0] r_best_chrom;
  logic [FITNESS_WIDTH-1:0]    r_best_fit;
  logic [ADDR_WIDTH-1:0]       r_best_addr;
  logic                        r_best_valid;

  // Read-side state: valid flags and which bank the last read came from.
  logic                        r_rd_valid_a;
  logic                        r_rd_valid_b;
  logic                        r_rd_sel_a;
  logic                        r_rd_sel_b;

  logic                        w_next_full;
  logic                        w_swap;
  logic                        w_addr_ok;
  logic                        w_mask_hit;
  logic                        w_wr_accept;
  logic                        w_sb_load;
  logic                        w_wr_en_b0;
  logic                        w_wr_en_b1;
  logic [EntryWidth-1:0]       w_wr_data;
  logic [EntryWidth-1:0]       w_b0_rd_a;
  logic [EntryWidth-1:0]       w_b0_rd_b;
  logic [EntryWidth-1:0]       w_b1_rd_a;
  logic [EntryWidth-1:0]       w_b1_rd_b;

  assign w_next_full = (r_wr_count == PopSize);
  assign w_swap      = swap_req & w_next_full;
  assign w_addr_ok   = ({1'b0, wr_addr} < PopSize);
  assign w_mask_hit  = w_addr_ok && r_mask[wr_addr];
  // A write in the swap cycle is refused so it cannot land in the bank going live.
  assign w_wr_accept = wr_en & w_addr_ok & ~w_mask_hit & ~w_swap;
  // First write of a generation always seeds the shadow best; ties keep the older one.
  assign w_sb_load   = w_wr_accept & ((r_wr_count == '0) | (wr_fit > r_sb_fit));
  assign w_wr_data   = {wr_chrom, wr_fit};
  // Shadow bank is the one not selected for reading.
  assign w_wr_en_b0  = w_wr_accept & ~rst & r_bank_sel;
  assign w_wr_en_b1  = w_wr_accept & ~rst & ~r_bank_sel;

  population_bank #(
    .DataWidth (EntryWidth),
    .Depth     (POPULATION_SIZE),
    .AddrWidth (ADDR_WIDTH)
  ) u_bank0 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_en     (w_wr_en_b0),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (w_wr_data),
    .i_rd_en_a   (rd_en_a & ~r_bank_sel),
    .i_rd_addr_a (rd_addr_a),
    .o_rd_data_a (w_b0_rd_a),
    .i_rd_en_b   (rd_en_b & ~r_bank_sel),
    .i_rd_addr_b (rd_addr_b),
    .o_rd_data_b (w_b0_rd_b)
  );

  population_bank #(
    .DataWidth (EntryWidth),
    .Depth     (POPULATION_SIZE),
    .AddrWidth (ADDR_WIDTH)
  ) u_bank1 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_en     (w_wr_en_b1),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (w_wr_data),
    .i_rd_en_a   (rd_en_a & r_bank_sel),
    .i_rd_addr_a (rd_addr_a),
    .o_rd_data_a (w_b1_rd_a),
    .i_rd_en_b   (rd_en_b & r_bank_sel),
    .i_rd_addr_b (rd_addr_b),
    .o_rd_data_b (w_b1_rd_b)
  );

  // Bank select, written mask, write count, write error and generation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_sel   <= 1'b0;
      r_mask       <= '0;
      r_wr_count   <= '0;
      r_wr_err     <= 1'b0;
      r_generation <= '0;
    end else begin
      r_wr_err <= wr_en & ~w_wr_accept;
      if (w_swap) begin
        r_bank_sel   <= ~r_bank_sel;
        r_mask       <= '0;
        r_wr_count   <= '0;
        r_generation <= r_generation + GenOne;
      end else if (w_wr_accept) begin
        r_mask[wr_addr] <= 1'b1;
        r_wr_count      <= r_wr_count + CountOne;
      end
    end
  end

  // Shadow-best tracking over accepted writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_chrom <= '0;
      r_sb_fit   <= '0;
      r_sb_addr  <= '0;
    end else if (w_sb_load) begin
      r_sb_chrom <= wr_chrom;
      r_sb_fit   <= wr_fit;
      r_sb_addr  <= wr_addr;
    end
  end

  // Publish the shadow best when the shadow bank goes live.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_best_chrom <= '0;
      r_best_fit   <= '0;
      r_best_addr  <= '0;
      r_best_valid <= 1'b0;
    end else if (w_swap) begin
      r_best_chrom <= r_sb_chrom;
      r_best_fit   <= r_sb_fit;
      r_best_addr  <= r_sb_addr;
      r_best_valid <= 1'b1;
    end
  end

  // Read valids, and remember the bank each port last read so held data survives a swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid_a <= 1'b0;
      r_rd_valid_b <= 1'b0;
      r_rd_sel_a   <= 1'b0;
      r_rd_sel_b   <= 1'b0;
    end else begin
      r_rd_valid_a <= rd_en_a;
      r_rd_valid_b <= rd_en_b;
      if (rd_en_a) begin
        r_rd_sel_a <= r_bank_sel;
      end
      if (rd_en_b) begin
        r_rd_sel_b <= r_bank_sel;
      end
    end
  end

  assign {rd_chrom_a, rd_fit_a} = r_rd_sel_a ? w_b1_rd_a : w_b0_rd_a;
  assign {rd_chrom_b, rd_fit_b} = r_rd_sel_b ? w_b1_rd_b : w_b0_rd_b;

  assign wr_err     = r_wr_err;
  assign wr_count   = r_wr_count;
  assign next_full  = w_next_full;
  assign rd_valid_a = r_rd_valid_a;
  assign rd_valid_b = r_rd_valid_b;
  assign swap_ack   = w_swap;
  assign best_chrom = r_best_chrom;
  assign best_fit   = r_best_fit;
  assign best_addr  = r_best_addr;
  assign best_valid = r_best_valid;
  assign generation = r_generation;

endmodule

// File: tb/tb_ga_population_buffer.sv
// Bench for ga_population_buffer: directed scenarios plus random traffic, all
// checked every cycle against a generation-level model of the buffer.
module tb_ga_population_buffer;

  localparam int CW = 16;
  localparam int FW = 14;
  localparam int PS = 16;
  localparam int AW = 4;
  localparam int GW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_en, rd_en_a, rd_en_b, swap_req;
  logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [CW-1:0] wr_chrom;
  logic [FW-1:0] wr_fit;
  logic          wr_err, next_full, rd_valid_a, rd_valid_b, swap_ack, best_valid;
  logic [AW:0]   wr_count;
  logic [CW-1:0] rd_chrom_a, rd_chrom_b, best_chrom;
  logic [FW-1:0] rd_fit_a, rd_fit_b, best_fit;
  logic [AW-1:0] best_addr;
  logic [GW-1:0] generation;

  ga_population_buffer u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_chrom(wr_chrom),
    .wr_fit(wr_fit), .wr_err(wr_err), .wr_count(wr_count), .next_full(next_full),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_chrom_a(rd_chrom_a),
    .rd_fit_a(rd_fit_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_chrom_b(rd_chrom_b),
    .rd_fit_b(rd_fit_b), .rd_valid_b(rd_valid_b),
    .swap_req(swap_req), .swap_ack(swap_ack), .best_chrom(best_chrom),
    .best_fit(best_fit), .best_addr(best_addr), .best_valid(best_valid),
    .generation(generation)
  );

  // Second instance with a non-power-of-two population for range checks.
  logic          s_rst, s_wr_en, s_rd_en_a, s_rd_en_b, s_swap_req;
  logic [3:0]    s_wr_addr, s_rd_addr_a, s_rd_addr_b;
  logic [CW-1:0] s_wr_chrom;
  logic [FW-1:0] s_wr_fit;
  logic          s_wr_err, s_next_full, s_rd_valid_a, s_rd_valid_b, s_swap_ack, s_best_valid;
  logic [4:0]    s_wr_count;
  logic [CW-1:0] s_rd_chrom_a, s_rd_chrom_b, s_best_chrom;
  logic [FW-1:0] s_rd_fit_a, s_rd_fit_b, s_best_fit;
  logic [3:0]    s_best_addr;
  logic [GW-1:0] s_generation;

  ga_population_buffer #(.POPULATION_SIZE(12)) u_dut12 (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_chrom(s_wr_chrom),
    .wr_fit(s_wr_fit), .wr_err(s_wr_err), .wr_count(s_wr_count), .next_full(s_next_full),
    .rd_en_a(s_rd_en_a), .rd_addr_a(s_rd_addr_a), .rd_chrom_a(s_rd_chrom_a),
    .rd_fit_a(s_rd_fit_a), .rd_valid_a(s_rd_valid_a),
    .rd_en_b(s_rd_en_b), .rd_addr_b(s_rd_addr_b), .rd_chrom_b(s_rd_chrom_b),
    .rd_fit_b(s_rd_fit_b), .rd_valid_b(s_rd_valid_b),
    .swap_req(s_swap_req), .swap_ack(s_swap_ack), .best_chrom(s_best_chrom),
    .best_fit(s_best_fit), .best_addr(s_best_addr), .best_valid(s_best_valid),
    .generation(s_generation)
  );

  int checks = 0;
  int errors = 0;

  // Model: logical active/shadow generations, not physical banks.
  logic [CW-1:0] m_act_c [PS];
  logic [FW-1:0] m_act_f [PS];
  logic [CW-1:0] m_sh_c  [PS];
  logic [FW-1:0] m_sh_f  [PS];
  bit            m_mask  [PS];
  int            m_order [$];
  int            m_count, m_gen, m_ba;
  bit            m_err, m_bv, m_rdv_a, m_rdv_b, m_rdk_a, m_rdk_b;
  logic [CW-1:0] m_rdc_a, m_rdc_b, m_bc;
  logic [FW-1:0] m_rdf_a, m_rdf_b, m_bf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    foreach (m_mask[i]) m_mask[i] = 1'b0;
    m_order.delete();
    m_count = 0; m_gen = 0; m_ba = 0;
    m_err = 0; m_bv = 0;
    m_rdv_a = 0; m_rdv_b = 0; m_rdk_a = 1; m_rdk_b = 1;
    m_rdc_a = '0; m_rdc_b = '0; m_rdf_a = '0; m_rdf_b = '0;
    m_bc = '0; m_bf = '0;
  endfunction

  function automatic void model_edge();
    bit ack, acc;
    int maxf;
    if (rst) begin
      model_reset();
      return;
    end
    ack = swap_req && (m_count == PS);
    m_rdv_a = rd_en_a;
    if (rd_en_a) begin
      m_rdk_a = m_bv;
      m_rdc_a = m_act_c[int'(rd_addr_a)];
      m_rdf_a = m_act_f[int'(rd_addr_a)];
    end
    m_rdv_b = rd_en_b;
    if (rd_en_b) begin
      m_rdk_b = m_bv;
      m_rdc_b = m_act_c[int'(rd_addr_b)];
      m_rdf_b = m_act_f[int'(rd_addr_b)];
    end
    acc = wr_en && (int'(wr_addr) < PS) && !m_mask[int'(wr_addr)] && !ack;
    m_err = wr_en && !acc;
    if (acc) begin
      m_sh_c[int'(wr_addr)] = wr_chrom;
      m_sh_f[int'(wr_addr)] = wr_fit;
      m_mask[int'(wr_addr)] = 1'b1;
      m_count++;
      m_order.push_back(int'(wr_addr));
    end
    if (ack) begin
      // Best = highest fitness; among equals, the earliest written.
      maxf = -1;
      foreach (m_order[k]) if (int'(m_sh_f[m_order[k]]) > maxf) maxf = int'(m_sh_f[m_order[k]]);
      for (int k = m_order.size() - 1; k >= 0; k--) begin
        if (int'(m_sh_f[m_order[k]]) == maxf) m_ba = m_order[k];
      end
      m_bc = m_sh_c[m_ba];
      m_bf = m_sh_f[m_ba];
      m_bv = 1;
      m_gen = (m_gen + 1) % (1 << GW);
      foreach (m_act_c[i]) begin
        m_act_c[i] = m_sh_c[i];
        m_act_f[i] = m_sh_f[i];
        m_mask[i]  = 1'b0;
      end
      m_count = 0;
      m_order.delete();
    end
  endfunction

  task automatic compare_outputs();
    chk("wr_err", wr_err, m_err);
    chk("wr_count", wr_count, m_count);
    chk("next_full", next_full, m_count == PS);
    chk("rd_valid_a", rd_valid_a, m_rdv_a);
    chk("rd_valid_b", rd_valid_b, m_rdv_b);
    if (m_rdk_a) begin
      chk("rd_chrom_a", rd_chrom_a, m_rdc_a);
      chk("rd_fit_a", rd_fit_a, m_rdf_a);
    end
    if (m_rdk_b) begin
      chk("rd_chrom_b", rd_chrom_b, m_rdc_b);
      chk("rd_fit_b", rd_fit_b, m_rdf_b);
    end
    chk("best_valid", best_valid, m_bv);
    chk("best_chrom", best_chrom, m_bc);
    chk("best_fit", best_fit, m_bf);
    chk("best_addr", best_addr, m_ba);
    chk("generation", generation, m_gen);
  endtask

  // One clock: check the combinational ack mid-cycle, then model and outputs after the edge.
  task automatic cycle();
    @(negedge clk);
    chk("swap_ack", swap_ack, swap_req && (m_count == PS));
    @(posedge clk);
    model_edge();
    #1 compare_outputs();
  endtask

  task automatic idle();
    wr_en = 0; rd_en_a = 0; rd_en_b = 0;
  endtask

  task automatic wr(input int a, input logic [CW-1:0] c, input logic [FW-1:0] f);
    wr_en = 1; wr_addr = a[AW-1:0]; wr_chrom = c; wr_fit = f;
  endtask

  task automatic s_tick();
    @(posedge clk);
    #1;
  endtask

  logic [CW-1:0] d1, d2;

  initial begin
    rst = 1; swap_req = 0; idle();
    wr_addr = '0; wr_chrom = '0; wr_fit = '0; rd_addr_a = '0; rd_addr_b = '0;
    s_rst = 1; s_wr_en = 0; s_rd_en_a = 0; s_rd_en_b = 0; s_swap_req = 0;
    s_wr_addr = '0; s_rd_addr_a = '0; s_rd_addr_b = '0; s_wr_chrom = '0; s_wr_fit = '0;
    model_reset();
    cycle();
    chk("reset_wr_count", wr_count, 0);
    chk("reset_generation", generation, 0);
    rst = 0;

    // Generation 1: fitness = 3*addr.
    d1 = '0;
    for (int a = 0; a < PS; a++) begin
      wr(a, CW'($urandom), FW'(3 * a));
      if (a == 7) d1 = wr_chrom;
      cycle();
    end
    idle();
    chk("full_after_16", next_full, 1);
    swap_req = 1;
    #1 chk("swap_ack_gen1", swap_ack, 1);
    cycle();
    swap_req = 0;
    chk("gen1_best_fit", best_fit, 45);
    chk("gen1_best_addr", best_addr, 15);
    chk("gen1_best_valid", best_valid, 1);
    chk("gen1_generation", generation, 1);

    // Generation 2: duplicate write rejected, tie at 2 and 9, d2 at 7.
    d2 = ~d1;
    wr(4, CW'($urandom), 14'd100);
    cycle();
    wr(4, CW'($urandom), 14'h3FFF);
    cycle();
    chk("dup_wr_err", wr_err, 1);
    chk("dup_wr_count", wr_count, 1);
    chk("dup_best_fit", best_fit, 45);
    for (int a = 0; a < PS; a++) begin
      if (a == 4) continue;
      wr(a, (a == 7) ? d2 : CW'($urandom),
         (a == 2 || a == 9) ? 14'h3FFF : FW'($urandom_range(0, 16'h3FFE)));
      cycle();
    end
    idle();
    swap_req = 1; rd_en_a = 1; rd_en_b = 1; rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    #1 chk("swap_ack_gen2", swap_ack, 1);
    cycle();
    swap_req = 0;
    chk("swap_read_a_old", rd_chrom_a, d1);
    chk("swap_read_b_old", rd_chrom_b, d1);
    chk("tie_best_addr", best_addr, 2);
    chk("tie_best_fit", best_fit, 14'h3FFF);
    chk("gen2_generation", generation, 2);
    cycle();
    chk("post_swap_read_a", rd_chrom_a, d2);
    chk("post_swap_read_b", rd_chrom_b, d2);
    idle();
    cycle();
    chk("rd_valid_drop", rd_valid_a, 0);

    // swap_req held from reset; ack only after the 16th write.
    rst = 1; swap_req = 1;
    cycle();
    rst = 0;
    for (int a = 0; a < PS - 1; a++) begin
      wr(a, CW'($urandom), FW'($urandom));
      cycle();
    end
    wr(PS - 1, CW'($urandom), FW'($urandom));
    #1 chk("held_no_ack_15", swap_ack, 0);
    cycle();
    idle();
    #1 chk("held_ack_16", swap_ack, 1);
    cycle();
    swap_req = 0;

    // Mid-generation reset discards partial writes; reset beats a coincident write.
    for (int a = 0; a < 8; a++) begin
      wr(a, CW'($urandom), FW'($urandom));
      cycle();
    end
    rst = 1; wr(9, 16'h1234, 14'h0042); rd_en_a = 1; swap_req = 1;
    cycle();
    chk("rst_wr_count", wr_count, 0);
    chk("rst_best_valid", best_valid, 0);
    chk("rst_rd_valid", rd_valid_a, 0);
    chk("rst_rd_chrom", rd_chrom_a, 0);
    chk("rst_generation", generation, 0);
    rst = 0; idle();
    for (int a = 0; a < PS; a++) begin
      wr(a, CW'($urandom), FW'($urandom));
      if (a == PS - 1) #1 chk("fresh_no_ack_15", swap_ack, 0);
      cycle();
    end
    idle();
    #1 chk("fresh_ack_16", swap_ack, 1);
    cycle();
    swap_req = 0;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int free_q[$];
      int a;
      rst = ($urandom_range(0, 299) == 0);
      wr_en = ($urandom_range(0, 9) < 7);
      foreach (m_mask[i]) if (!m_mask[i]) free_q.push_back(i);
      if (free_q.size() > 0 && $urandom_range(0, 1) == 1)
        a = free_q[$urandom_range(0, free_q.size() - 1)];
      else
        a = $urandom_range(0, PS - 1);
      wr_addr = a[AW-1:0];
      wr_chrom = CW'($urandom);
      case ($urandom_range(0, 3))
        0: wr_fit = 14'h3FFF;
        1: wr_fit = FW'($urandom_range(0, 3));
        default: wr_fit = FW'($urandom);
      endcase
      rd_en_a = ($urandom_range(0, 9) < 6);
      rd_en_b = ($urandom_range(0, 9) < 6);
      rd_addr_a = AW'($urandom);
      rd_addr_b = AW'($urandom);
      swap_req = ($urandom_range(0, 2) != 0);
      cycle();
    end
    rst = 0; idle(); swap_req = 0;
    cycle();

    // POPULATION_SIZE = 12 instance: out-of-range write and read.
    s_tick();
    s_rst = 0;
    s_wr_en = 1; s_wr_addr = 4'd13; s_wr_fit = 14'd7; s_wr_chrom = 16'hBEEF;
    s_tick();
    chk("s12_oor_wr_err", s_wr_err, 1);
    chk("s12_oor_wr_count", s_wr_count, 0);
    s_wr_addr = 4'd3; s_wr_fit = 14'd3; s_wr_chrom = 16'h0003;
    s_tick();
    chk("s12_ok_wr_err", s_wr_err, 0);
    chk("s12_ok_wr_count", s_wr_count, 1);
    s_wr_en = 0; s_rd_en_a = 1; s_rd_addr_a = 4'd14;
    s_tick();
    chk("s12_oor_rd_valid", s_rd_valid_a, 1);
    chk("s12_oor_rd_chrom", s_rd_chrom_a, 0);
    chk("s12_oor_rd_fit", s_rd_fit_a, 0);
    s_rd_en_a = 0;
    for (int a = 0; a < 12; a++) begin
      if (a == 3) continue;
      s_wr_en = 1; s_wr_addr = a[3:0]; s_wr_fit = FW'(a); s_wr_chrom = CW'(16'hA000 + a);
      s_tick();
    end
    s_wr_en = 0;
    chk("s12_full", s_next_full, 1);
    chk("s12_count", s_wr_count, 12);
    s_swap_req = 1;
    #1 chk("s12_swap_ack", s_swap_ack, 1);
    s_tick();
    s_swap_req = 0;
    chk("s12_generation", s_generation, 1);
    chk("s12_best_addr", s_best_addr, 11);
    chk("s12_best_fit", s_best_fit, 11);
    s_rd_en_b = 1; s_rd_addr_b = 4'd11;
    s_tick();
    chk("s12_rd_b_chrom", s_rd_chrom_b, 16'hA00B);
    s_rd_en_b = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
